// File: rtl/tdm_demux8.sv
// -----------------------------------------------------------------------------
// tdm_demux8 -- receive end of an 8-channel time-division serial link.
//
// The transmitter walks an 8:1 select 0..7 and sends one bit per slot. This
// block samples the line on each slot strobe and tracks the slot number with a
// 3-bit counter that a frame-sync marker aligns to slot 0. It then presents
// each complete frame as one registered 8-bit word.
//
// Parameters
//   CHECK_SYNC  1: frame_sync must accompany every slot 0 while locked, and a
//                  missing sync drops lock. 0: free-run once locked.
//   RESET_OUT   value held on out after reset.
//
// Ports
//   clk         input   rising-edge system clock
//   rst_n       input   asynchronous active-low reset
//   en          input   slot strobe; din/frame_sync are sampled only when high
//   frame_sync  input   marks the current din bit as slot 0
//   din         input   serial channel bit for the current slot
//   out         output  [7:0] last complete frame, out[k] = channel k
//   frame_valid output  one-cycle pulse when out is updated
//   sel         output  [2:0] slot expected on the next strobe
//   locked      output  1 while aligned to frames
//   sync_err    output  one-cycle pulse on an alignment violation
// -----------------------------------------------------------------------------
module tdm_demux8 #(
  parameter bit         CHECK_SYNC = 1'b1,
  parameter logic [7:0] RESET_OUT  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       frame_sync,
  input  logic       din,
  output logic [7:0] out,
  output logic       frame_valid,
  output logic [2:0] sel,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_sel,   w_sel_nxt;
  // Slots 0..6 are buffered here; slot 7 goes straight into out with them.
  logic [6:0] r_cap,   w_cap_nxt;
  logic [7:0] r_out,   w_out_nxt;
  logic       r_fv,    w_fv_nxt;
  logic       r_err,   w_err_nxt;
  logic       r_locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_HUNT;
      r_sel    <= 3'd0;
      r_cap    <= 7'd0;
      r_out    <= RESET_OUT;
      r_fv     <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_cap    <= w_cap_nxt;
      r_out    <= w_out_nxt;
      r_fv     <= w_fv_nxt;
      r_err    <= w_err_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cap_nxt   = r_cap;
    w_out_nxt   = r_out;
    w_fv_nxt    = 1'b0;
    w_err_nxt   = 1'b0;

    if (en) begin
      unique case (r_state)
        ST_HUNT: begin
          if (frame_sync) begin
            w_cap_nxt[0] = din;
            w_sel_nxt    = 3'd1;
            w_state_nxt  = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (frame_sync) begin
            // A sync anywhere but slot 0 (including slot 7) abandons the
            // partial frame and restarts alignment on this bit.
            w_err_nxt    = (r_sel != 3'd0);
            w_cap_nxt[0] = din;
            w_sel_nxt    = 3'd1;
          end else if (r_sel == 3'd0) begin
            if (CHECK_SYNC) begin
              w_err_nxt   = 1'b1;
              w_sel_nxt   = 3'd0;
              w_state_nxt = ST_HUNT;
            end else begin
              w_cap_nxt[0] = din;
              w_sel_nxt    = 3'd1;
            end
          end else if (r_sel == 3'd7) begin
            w_out_nxt = {din, r_cap};
            w_fv_nxt  = 1'b1;
            w_sel_nxt = 3'd0;
          end else begin
            w_cap_nxt[r_sel] = din;
            w_sel_nxt        = r_sel + 3'd1;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  assign out         = r_out;
  assign frame_valid = r_fv;
  assign sel         = r_sel;
  assign locked      = r_locked;
  assign sync_err    = r_err;

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive end of the 8-channel time-division link. The transmit side walks an 8:1 mux select 0..7 and drives one serial bit per slot.
- This block samples the serial line once per slot strobe and tracks the slot number with a 3-bit counter aligned by a frame-sync marker.
- It rebuilds the 8 channel bits and presents them as one registered parallel word per frame, with a valid pulse and lock/error status.

Parameters:
- CHECK_SYNC, 1: 1 = frame_sync is required on every slot 0 while locked, and a missing sync drops lock; 0 = free-run once locked, so a missing sync is not an error.
- RESET_OUT, 8'h00: value loaded into out on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  slot strobe; din and frame_sync are sampled only on clk edges with en=1.
- frame_sync  input  1  marks the current din bit as slot 0 (channel in0).
- din  input  1  serial channel bit for the current slot.
- out  output  8  last complete frame; out[k] = channel k (in0..in7).
- frame_valid  output  1  one-cycle pulse when out is updated.
- sel  output  3  slot number expected on the next strobe (mirrors the transmit-side sel2..sel0).
- locked  output  1  1 = aligned to frames.
- sync_err  output  1  one-cycle pulse on an alignment violation.

Behaviour:
- Reset (async, rst_n=0): out=RESET_OUT, frame_valid=0, sync_err=0, locked=0, sel=0, capture register=0, state=HUNT.
- Reset release takes effect on the next clk edge. Reset mid-frame discards the partial frame, and out returns to RESET_OUT.
- All outputs are registered. frame_valid and sync_err default to 0 on every cycle unless set below.
- Edges with en=0 change nothing: frame_sync and din are ignored, and sel holds.
- State HUNT:
  - Strobe with frame_sync=0: ignored, no error.
  - Strobe with frame_sync=1: capture[0]<=din, sel<=1, state->LOCKED, locked<=1.
- State LOCKED, strobe with sel=s:
  - frame_sync=1 and s=0: normal slot 0; capture[0]<=din, sel<=1.
  - frame_sync=1 and s!=0 (early sync): sync_err<=1 and the partial frame is discarded, with no frame_valid. The bit is taken as the new slot 0: capture[0]<=din, sel<=1, and the block stays LOCKED.
  - frame_sync=0 and s=0 with CHECK_SYNC=1 (missing sync): sync_err<=1, state->HUNT, locked<=0, sel<=0, bit discarded.
  - frame_sync=0 and s=0 with CHECK_SYNC=0: treated as slot 0; capture[0]<=din, sel<=1.
  - frame_sync=0 and 1<=s<=6: capture[s]<=din, sel<=s+1.
  - s=7 (frame_sync=0): out<={din, capture[6:0]}, frame_valid<=1, sel wraps to 0, capture unchanged.
- Latency: out and frame_valid are visible the cycle after the edge that samples slot 7. out holds until the next complete frame.
- Back-to-back frames (en held high) give frame_valid every 8th cycle with no gaps.
- Sync handling during a completion: frame_sync=1 on the slot-7 strobe counts as early sync. sync_err=1, no frame_valid, out unchanged.
- capture bits are overwritten, never cleared, between frames. A stale bit never reaches out, because out loads only on a full 0..7 sequence.

Test Plan:
- Reset, then 8 strobes with frame_sync on the first and din=1,0,1,1,0,0,1,0 (slots 0..7) -> out=8'h4D one cycle after the 8th strobe, frame_valid high for exactly 1 cycle, locked=1, sel=0.
- Strobes in HUNT with frame_sync=0 and din=1 -> out=8'h00, locked=0, no pulses. A following sync frame with all din=1 -> out=8'hFF.
- Locked; frame_sync asserted at slot 4 -> sync_err pulse, no frame_valid, sel=1 next, and the following clean frame 8'hA5 -> out=8'hA5.
- CHECK_SYNC=1, locked; slot-0 strobe without frame_sync -> sync_err pulse, locked=0, sel=0. Repeat with CHECK_SYNC=0 -> no error, frame 8'h3C decoded.
- en toggled 1/0 every cycle during a frame of 8'h96 -> out=8'h96; sel holds on en=0 cycles.
- rst_n pulsed low asynchronously (between clk edges) at slot 5 of a frame -> out=8'h00, locked=0 immediately. A new synced frame 8'h01 decodes correctly.
